mux_nto1_pipe: RTL and testbench

Parametrised N-input, WIDTH-bit selector with registered output, for the pipeline datapath (forwarding and operand source selection at a stage boundary).
- Output is registered through STAGES pipeline registers, each with a valid bit.
- Supports stall (hold) and flush (bubble insertion) from hazard control.
- Select may be binary-coded or one-hot, chosen by parameter.
- Flags illegal selects instead of silently aliasing.

---
 rtl/mux_nto1_pipe.sv | 134 +++++++++++++
 tb/tb_mux_nto1_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: N-input, WIDTH-bit source selector with a STAGES-deep
// registered output. Each stage carries {data, valid, err}. Hazard control
// can hold the pipe (stall) or kill every in-flight beat (flush).
// Illegal selects are flagged and never silently aliased onto another input.
module mux_nto1_pipe #(
   parameter  int WIDTH  = 32,
   parameter  int N      = 4,
   parameter  int ONEHOT = 0,
   parameter  int STAGES = 1,
   localparam int SEL_W  = (ONEHOT != 0) ? N : $clog2(N)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               flush_i,
   input  logic               valid_i,
   input  logic [SEL_W-1:0]   select_i,
   input  logic [N*WIDTH-1:0] data_i,
   output logic [WIDTH-1:0]   data_o,
   output logic               valid_o,
   output logic               sel_err_o
);

   // Stage-0 candidate produced by the selector.
   logic [WIDTH-1:0]  sel_data_s;
   logic              sel_err_s;

   // Pipeline stage state; index 0 is the stage nearest the inputs.
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] err_q;
   logic [STAGES-1:0] err_d;

   // Number of set bits in a select word; N is at most 16, so 5 bits suffice.
   function automatic logic [4:0] count_ones(input logic [SEL_W-1:0] v);
      logic [4:0] c;
      c = 5'd0;
      for (int k = 0; k < SEL_W; k++) begin
         c = c + {4'd0, v[k]};
      end
      return c;
   endfunction

   if (ONEHOT != 0) begin : g_onehot
      logic found_s;
      logic take_s;

      // One-hot decode: the lowest set bit wins; anything other than exactly
      // one set bit is flagged, and no bit set yields zero data.
      always_comb begin
         sel_data_s = '0;
         found_s    = 1'b0;
         take_s     = 1'b0;
         for (int k = 0; k < N; k++) begin
            take_s     = select_i[k] & ~found_s;
            sel_data_s = sel_data_s | ({WIDTH{take_s}} & data_i[k*WIDTH +: WIDTH]);
            found_s    = found_s | select_i[k];
         end
         sel_err_s = (count_ones(select_i) != 5'd1);
      end
   end else begin : g_binary
      logic hit_s;
      logic match_s;

      // Binary decode: an AND-OR mux over the legal codes, so a code >= N
      // matches nothing and yields zero data and the error flag.
      always_comb begin
         sel_data_s = '0;
         hit_s      = 1'b0;
         match_s    = 1'b0;
         for (int k = 0; k < N; k++) begin
            match_s    = (select_i == SEL_W'(k));
            sel_data_s = sel_data_s | ({WIDTH{match_s}} & data_i[k*WIDTH +: WIDTH]);
            hit_s      = hit_s | match_s;
         end
         sel_err_s = ~hit_s;
      end
   end

   // Next-state for all stages: data/err advance whenever the pipe is not
   // held (valid_i only tags them); valid is cleared by flush, held by stall.
   always_comb begin
      data_d  = data_q;
      err_d   = err_q;
      valid_d = valid_q;

      if (!stall_i) begin
         data_d[0] = sel_data_s;
         err_d[0]  = sel_err_s;
         for (int s = 1; s < STAGES; s++) begin
            data_d[s] = data_q[s-1];
            err_d[s]  = err_q[s-1];
         end
      end else begin
         // Held: a flush during a stall clears valid but does not move data.
         data_d = data_q;
         err_d  = err_q;
      end

      if (flush_i) begin
         valid_d = '0;
      end else if (!stall_i) begin
         valid_d[0] = valid_i;
         for (int s = 1; s < STAGES; s++) begin
            valid_d[s] = valid_q[s-1];
         end
      end else begin
         valid_d = valid_q;
      end
   end

   // Stage registers with synchronous reset, which overrides stall and flush.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < STAGES; s++) begin
            data_q[s] <= '0;
         end
         valid_q <= '0;
         err_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Outputs come straight from the last stage flops.
   assign data_o    = data_q[STAGES-1];
   assign valid_o   = valid_q[STAGES-1];
   assign sel_err_o = err_q[STAGES-1];

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe. Four configurations run side by side on shared
// control: binary N=4 (inst0), binary N=3 (inst1), one-hot N=4 (inst2) and
// binary N=4 with two stages (inst3). A small reference pipeline per instance
// pushes expected outputs to a scoreboard queue at every driven beat; each
// test pops the entry after the edge and compares the instances it targets.
module tb_mux_nto1_pipe;

   typedef struct packed {
      logic [3:0][31:0] d;
      logic [3:0]       v;
      logic [3:0]       e;
   } exp_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, flush, vin;
   logic [1:0]  sel0, sel1, sel3;
   logic [3:0]  sel2;
   logic [31:0] din [4];
   logic [127:0] bus;
   assign bus = {din[3], din[2], din[1], din[0]};

   logic [31:0] d0, d1, d2, d3;
   logic        v0, v1, v2, v3, e0, e1, e2, e3;
   logic [31:0] o_d [4];
   logic [3:0]  o_v, o_e;
   assign o_d[0] = d0;
   assign o_d[1] = d1;
   assign o_d[2] = d2;
   assign o_d[3] = d3;
   assign o_v = {v3, v2, v1, v0};
   assign o_e = {e3, e2, e1, e0};

   mux_nto1_pipe u0 (.clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .valid_i(vin), .select_i(sel0), .data_i(bus), .data_o(d0), .valid_o(v0), .sel_err_o(e0));
   mux_nto1_pipe #(.N(3)) u1 (.clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .valid_i(vin), .select_i(sel1), .data_i(bus[95:0]), .data_o(d1), .valid_o(v1), .sel_err_o(e1));
   mux_nto1_pipe #(.ONEHOT(1)) u2 (.clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .valid_i(vin), .select_i(sel2), .data_i(bus), .data_o(d2), .valid_o(v2), .sel_err_o(e2));
   mux_nto1_pipe #(.STAGES(2)) u3 (.clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .valid_i(vin), .select_i(sel3), .data_i(bus), .data_o(d3), .valid_o(v3), .sel_err_o(e3));

   exp_t        sb [$];
   exp_t        x;
   logic [31:0] md [4][2];
   logic [1:0]  mv [4];
   logic [1:0]  me [4];
   int          n_vec = 0;
   int          n_err = 0;

   // Reference selector for instance i (select zero-extended to 4 bits).
   function automatic void model_sel(input int i, input logic [3:0] s,
                                     output logic [31:0] d, output logic e);
      int cnt;
      d = 32'h0;
      e = 1'b0;
      cnt = 0;
      if (i == 2) begin
         for (int k = 3; k >= 0; k--) begin
            if (s[k]) begin
               d = din[k];
               cnt++;
            end
         end
         e = (cnt != 1);
      end else if (i == 1) begin
         if (s < 4'd3) d = din[s[1:0]];
         else e = 1'b1;
      end else begin
         d = din[s[1:0]];
      end
   endfunction

   // Advance the reference pipelines with the inputs about to be sampled,
   // push the expected post-edge outputs, then step past the edge.
   task automatic tick();
      exp_t        t;
      logic [31:0] cd;
      logic        ce;
      logic [3:0]  s;
      int          ns;
      for (int i = 0; i < 4; i++) begin
         ns = (i == 3) ? 2 : 1;
         s  = (i == 0) ? {2'b00, sel0} : (i == 1) ? {2'b00, sel1} :
              (i == 2) ? sel2 : {2'b00, sel3};
         model_sel(i, s, cd, ce);
         if (rst) begin
            md[i][0] = 32'h0; md[i][1] = 32'h0; mv[i] = 2'b00; me[i] = 2'b00;
         end else begin
            if (!stall) begin
               md[i][1] = md[i][0]; me[i][1] = me[i][0];
               md[i][0] = cd;       me[i][0] = ce;
            end
            if (flush) mv[i] = 2'b00;
            else if (!stall) mv[i] = {mv[i][0], vin};
         end
         t.d[i] = md[i][ns-1];
         t.v[i] = mv[i][ns-1];
         t.e[i] = me[i][ns-1];
      end
      sb.push_back(t);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b1; flush = 1'b0; vin = 1'b1;
      tick();
      x = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({o_v[i], o_e[i], o_d[i]} !== {1'b0, 1'b0, 32'h0} ||
             {o_v[i], o_e[i], o_d[i]} !== {x.v[i], x.e[i], x.d[i]}) begin
            n_err++;
            $display("FAIL reset inst%0d: got v=%b e=%b d=%h, want v=0 e=0 d=00000000",
                     i, o_v[i], o_e[i], o_d[i]);
         end
      end
      rst = 1'b0; stall = 1'b0;
   endtask

   task automatic test_binary_sweep();
      for (int s = 0; s < 4; s++) begin
         sel0 = 2'(s); sel3 = 2'(s); vin = 1'b1;
         tick();
         x = sb.pop_front();
         n_vec++;
         if ({o_v[0], o_e[0], o_d[0]} !== {x.v[0], x.e[0], x.d[0]}) begin
            n_err++;
            $display("FAIL binary_sweep sel=%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                     s, o_v[0], o_e[0], o_d[0], x.v[0], x.e[0], x.d[0]);
         end
      end
   endtask

   task automatic test_binary_oob();
      logic [1:0] sl [3];
      logic       vl [3];
      sl = '{2'd3, 2'd3, 2'd2};
      vl = '{1'b1, 1'b0, 1'b1};
      for (int j = 0; j < 3; j++) begin
         sel1 = sl[j]; vin = vl[j];
         tick();
         x = sb.pop_front();
         n_vec++;
         if ({o_v[1], o_e[1], o_d[1]} !== {x.v[1], x.e[1], x.d[1]}) begin
            n_err++;
            $display("FAIL binary_oob step%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                     j, o_v[1], o_e[1], o_d[1], x.v[1], x.e[1], x.d[1]);
         end
      end
   endtask

   task automatic test_onehot();
      logic [3:0] pat [6];
      pat = '{4'b0100, 4'b0110, 4'b0000, 4'b1000, 4'b1001, 4'b0001};
      vin = 1'b1;
      for (int j = 0; j < 6; j++) begin
         sel2 = pat[j];
         tick();
         x = sb.pop_front();
         n_vec++;
         if ({o_v[2], o_e[2], o_d[2]} !== {x.v[2], x.e[2], x.d[2]}) begin
            n_err++;
            $display("FAIL onehot sel=%b: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                     pat[j], o_v[2], o_e[2], o_d[2], x.v[2], x.e[2], x.d[2]);
         end
      end
   endtask

   task automatic test_stall_stream();
      logic [1:0] sl [8];
      logic       st [8];
      sl = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd0};
      st = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vin = 1'b1;
      for (int j = 0; j < 8; j++) begin
         sel0 = sl[j]; sel3 = sl[j]; stall = st[j];
         din[3] = st[j] ? 32'hDEADBEEF : 32'h44444444;
         tick();
         x = sb.pop_front();
         for (int i = 0; i < 4; i += 3) begin
            n_vec++;
            if ({o_v[i], o_e[i], o_d[i]} !== {x.v[i], x.e[i], x.d[i]}) begin
               n_err++;
               $display("FAIL stall_stream step%0d inst%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                        j, i, o_v[i], o_e[i], o_d[i], x.v[i], x.e[i], x.d[i]);
            end
         end
      end
      stall = 1'b0; din[3] = 32'h44444444;
   endtask

   task automatic test_stall_flush();
      logic st [6];
      logic fl [6];
      st = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      fl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vin = 1'b1;
      for (int j = 0; j < 6; j++) begin
         stall = st[j]; flush = fl[j];
         sel0 = 2'(j); sel3 = 2'(j + 1);
         tick();
         x = sb.pop_front();
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({o_v[i], o_e[i], o_d[i]} !== {x.v[i], x.e[i], x.d[i]}) begin
               n_err++;
               $display("FAIL stall_flush step%0d inst%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                        j, i, o_v[i], o_e[i], o_d[i], x.v[i], x.e[i], x.d[i]);
            end
         end
      end
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      logic rs [5];
      logic st [5];
      rs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      st = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vin = 1'b1;
      for (int j = 0; j < 5; j++) begin
         rst = rs[j]; stall = st[j];
         sel0 = 2'(3 - j); sel3 = 2'(j);
         tick();
         x = sb.pop_front();
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({o_v[i], o_e[i], o_d[i]} !== {x.v[i], x.e[i], x.d[i]}) begin
               n_err++;
               $display("FAIL reset_mid_stall step%0d inst%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                        j, i, o_v[i], o_e[i], o_d[i], x.v[i], x.e[i], x.d[i]);
            end
         end
      end
      rst = 1'b0; stall = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int j = 0; j < 60; j++) begin
         for (int k = 0; k < 4; k++) din[k] = $urandom;
         sel0  = 2'($urandom_range(0, 3));
         sel1  = 2'($urandom_range(0, 3));
         sel2  = 4'($urandom_range(0, 15));
         sel3  = 2'($urandom_range(0, 3));
         vin   = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 7) == 0);
         rst   = ($urandom_range(0, 29) == 0);
         tick();
         x = sb.pop_front();
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({o_v[i], o_e[i], o_d[i]} !== {x.v[i], x.e[i], x.d[i]}) begin
               n_err++;
               $display("FAIL back_to_back cyc%0d inst%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                        j, i, o_v[i], o_e[i], o_d[i], x.v[i], x.e[i], x.d[i]);
            end
         end
      end
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; flush = 1'b0; vin = 1'b0;
      sel0 = 2'd0; sel1 = 2'd0; sel2 = 4'b0001; sel3 = 2'd0;
      din[0] = 32'h11111111; din[1] = 32'h22222222;
      din[2] = 32'h33333333; din[3] = 32'h44444444;
      #2;
      test_reset();
      test_binary_sweep();
      test_binary_oob();
      test_onehot();
      test_stall_stream();
      test_stall_flush();
      test_reset_mid_stall();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
